imm_gen_stage: RTL and testbench

- Pipelined, parametrised immediate generator for the decode stage.
- Classifies each 32-bit instruction by format (I/S/B/U/J plus CSR zimm) and emits an XLEN-wide extended immediate, a type code, an illegal flag and a pass-through tag.
- Sits between fetch/IF-ID and the decode/ID-EX register, with a valid/ready handshake and a 2-entry skid buffer, so in_ready is a register output.

---
 rtl/imm_gen_stage.sv | 143 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: classifies a 32-bit instruction by format and
// emits the extended immediate behind a valid/ready stage with a one-entry skid buffer.
module imm_gen_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 8,
    parameter bit          RV64_OPS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    localparam int ENT_W = XLEN + 3 + 1 + TAG_W;

    logic [4:0]       opcode;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_type;
    logic             dec_ill;
    logic [ENT_W-1:0] dec_ent;
    logic [ENT_W-1:0] main_ent;
    logic [ENT_W-1:0] skid_ent;
    logic             main_valid;
    logic             skid_valid;
    logic             main_free;
    logic             in_fire;

    assign opcode = in_inst[6:2];

    // Size casts of signed fields give sign extension to XLEN (truncation when XLEN=32).
    always_comb begin
        dec_imm  = '0;
        dec_type = T_NONE;
        dec_ill  = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (opcode)
                5'b00100, 5'b00000, 5'b11001: begin
                    dec_type = T_I;
                    dec_imm  = XLEN'($signed(in_inst[31:20]));
                end
                5'b00110: begin
                    if (RV64_OPS) begin
                        dec_type = T_I;
                        dec_imm  = XLEN'($signed(in_inst[31:20]));
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                5'b01000: begin
                    dec_type = T_S;
                    dec_imm  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                end
                5'b11000: begin
                    dec_type = T_B;
                    dec_imm  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                              in_inst[11:8], 1'b0}));
                end
                5'b00101, 5'b01101: begin
                    dec_type = T_U;
                    dec_imm  = XLEN'($signed({in_inst[31:12], 12'b0}));
                end
                5'b11011: begin
                    dec_type = T_J;
                    dec_imm  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                              in_inst[30:21], 1'b0}));
                end
                5'b11100: begin
                    if (in_inst[14]) begin
                        dec_type = T_Z;
                        dec_imm  = XLEN'(in_inst[19:15]);
                    end
                end
                5'b01100, 5'b00011: begin
                    dec_type = T_NONE;
                end
                5'b01110: begin
                    dec_ill = !RV64_OPS;
                end
                default: begin
                    dec_ill = 1'b1;
                end
            endcase
        end
    end

    assign dec_ent   = {dec_imm, dec_type, dec_ill, in_tag};
    assign in_ready  = !skid_valid;
    assign in_fire   = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ent   <= '0;
            skid_ent   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // Skid is older than anything on the input, so it drains first.
            if (skid_valid) begin
                main_ent   <= skid_ent;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) begin
                    main_ent <= dec_ent;
                end
            end
        end else if (in_fire) begin
            skid_ent   <= dec_ent;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_ent[ENT_W-1 -: XLEN];
    assign out_type    = main_ent[TAG_W+3 -: 3];
    assign out_illegal = main_ent[TAG_W];
    assign out_tag     = main_ent[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=32/RV64_OPS=0 and an XLEN=64/RV64_OPS=1 instance
// share stimulus; directed scenarios plus a randomized run against a queue model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64;
    logic [7:0]  tag32, tag64;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  op_tab [12];
    logic [39:0] q [$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(8), .RV64_OPS(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(typ32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(8), .RV64_OPS(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(typ64), .out_illegal(ill64), .out_tag(tag64)
    );

    // Reference decode from field arithmetic: immediate as a signed integer value.
    function automatic void ref_dec(input logic [31:0] inst, input bit rv64,
                                    output bit ill, output logic [2:0] typ, output longint v);
        longint a, b, c, d, e;
        ill = 1'b0;
        typ = 3'd0;
        v   = 0;
        if (inst[1:0] != 2'b11) begin
            ill = 1'b1;
            return;
        end
        case (inst[6:2])
            5'b00100, 5'b00000, 5'b11001, 5'b00110: begin
                if (inst[6:2] == 5'b00110 && !rv64) begin
                    ill = 1'b1;
                end else begin
                    typ = 3'd1;
                    v = inst[31:20];
                    if (v >= 2048) v = v - 4096;
                end
            end
            5'b01000: begin
                typ = 3'd2;
                a = inst[31:25];
                b = inst[11:7];
                v = a * 32 + b;
                if (v >= 2048) v = v - 4096;
            end
            5'b11000: begin
                typ = 3'd3;
                a = inst[31]; b = inst[7]; c = inst[30:25]; d = inst[11:8];
                v = a * 4096 + b * 2048 + c * 32 + d * 2;
                if (v >= 4096) v = v - 8192;
            end
            5'b00101, 5'b01101: begin
                typ = 3'd4;
                a = inst[31:12];
                v = a * 4096;
                if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
            end
            5'b11011: begin
                typ = 3'd5;
                a = inst[31]; b = inst[19:12]; c = inst[20]; d = inst[30:21];
                v = a * 1048576 + b * 4096 + c * 2048 + d * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            5'b11100: begin
                if (inst[14]) begin
                    typ = 3'd6;
                    e = inst[19:15];
                    v = e;
                end
            end
            5'b01100, 5'b00011: typ = 3'd0;
            5'b01110: ill = !rv64;
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(3) != 0) begin
            r[6:2] = op_tab[$urandom_range(11)];
            r[1:0] = 2'b11;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
        #1;
        n_tests++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid32: got %b want 0", vld32); end
        n_tests++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_ready32: got %b want 1", rdy32); end
        n_tests++; if (imm32 !== 32'h0) begin n_fail++; $display("FAIL reset_imm32: got %h want 0", imm32); end
        n_tests++; if ({typ32, ill32, tag32} !== 12'h0) begin n_fail++; $display("FAIL reset_fields32: got %h want 0", {typ32, ill32, tag32}); end
        n_tests++; if (vld64 !== 1'b0 || rdy64 !== 1'b1) begin n_fail++; $display("FAIL reset_hs64: got v=%b r=%b want v=0 r=1", vld64, rdy64); end
        n_tests++; if ({imm64, typ64, ill64, tag64} !== 76'h0) begin n_fail++; $display("FAIL reset_fields64: got %h want 0", {imm64, typ64, ill64, tag64}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ins  [10];
        logic [2:0]  t32  [10];
        logic [2:0]  t64  [10];
        logic        i32f [10];
        logic        i64f [10];
        logic [63:0] e64  [10];
        logic [31:0] e32  [10];
        ins  = '{32'hFFF00093, 32'hFE112E23, 32'h300FD073, 32'h800002B7, 32'h00000000,
                 32'h8000001B, 32'h0000003B, 32'hFE000FE3, 32'h0010006F, 32'h00000033};
        t32  = '{3'd1, 3'd2, 3'd6, 3'd4, 3'd0, 3'd0, 3'd0, 3'd3, 3'd5, 3'd0};
        t64  = '{3'd1, 3'd2, 3'd6, 3'd4, 3'd0, 3'd1, 3'd0, 3'd3, 3'd5, 3'd0};
        i32f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        i64f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e32  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h1F, 32'h80000000, 32'h0,
                 32'h0, 32'h0, 32'hFFFFFFFE, 32'h800, 32'h0};
        e64  = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h1F, 64'hFFFFFFFF_80000000, 64'h0,
                 64'hFFFFFFFF_FFFFF800, 64'h0, 64'hFFFFFFFF_FFFFFFFE, 64'h800, 64'h0};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_inst = ins[i]; in_tag = 8'h10 + 8'(i);
            @(negedge clk);
            in_valid = 1'b0;
            n_tests++; if (vld32 !== 1'b1 || vld64 !== 1'b1) begin n_fail++; $display("FAIL dec_valid[%0d]: got %b/%b want 1/1", i, vld32, vld64); end
            n_tests++; if (typ32 !== t32[i] || ill32 !== i32f[i]) begin n_fail++; $display("FAIL dec_type32[%0d]: got t=%0d ill=%b want t=%0d ill=%b", i, typ32, ill32, t32[i], i32f[i]); end
            n_tests++; if (imm32 !== e32[i]) begin n_fail++; $display("FAIL dec_imm32[%0d]: got %h want %h", i, imm32, e32[i]); end
            n_tests++; if (typ64 !== t64[i] || ill64 !== i64f[i]) begin n_fail++; $display("FAIL dec_type64[%0d]: got t=%0d ill=%b want t=%0d ill=%b", i, typ64, ill64, t64[i], i64f[i]); end
            n_tests++; if (imm64 !== e64[i]) begin n_fail++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, imm64, e64[i]); end
            n_tests++; if (tag32 !== 8'h10 + 8'(i) || tag64 !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL dec_tag[%0d]: got %h/%h want %h", i, tag32, tag64, 8'h10 + 8'(i)); end
        end
        @(negedge clk);
        n_tests++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL dec_drain: got %b want 0", vld32); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 8'hA1;
        @(negedge clk);
        n_tests++; if (vld32 !== 1'b1 || tag32 !== 8'hA1 || rdy32 !== 1'b1) begin n_fail++; $display("FAIL bp_a: got v=%b tag=%h r=%b want v=1 tag=a1 r=1", vld32, tag32, rdy32); end
        in_inst = 32'hFE112E23; in_tag = 8'hB2;
        @(negedge clk);
        n_tests++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || tag32 !== 8'hA1) begin n_fail++; $display("FAIL bp_b: got r=%b/%b tag=%h want r=0 tag=a1", rdy32, rdy64, tag32); end
        in_inst = 32'h300FD073; in_tag = 8'hC3;
        @(negedge clk);
        n_tests++; if (rdy32 !== 1'b0 || tag32 !== 8'hA1 || imm32 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bp_hold: got r=%b tag=%h imm=%h want r=0 tag=a1 imm=ffffffff", rdy32, tag32, imm32); end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (vld32 !== 1'b1 || tag32 !== 8'hB2 || rdy32 !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got v=%b tag=%h r=%b want v=1 tag=b2 r=1", vld32, tag32, rdy32); end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (vld32 !== 1'b1 || tag32 !== 8'hC3 || typ32 !== 3'd6) begin n_fail++; $display("FAIL bp_out_c: got v=%b tag=%h t=%0d want v=1 tag=c3 t=6", vld32, tag32, typ32); end
        @(negedge clk);
        n_tests++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b/%b want 0/0", vld32, vld64); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000013; in_tag = 8'h51;
        @(negedge clk);
        in_tag = 8'h52;
        @(negedge clk);
        n_tests++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL flush_full: got r=%b want 0", rdy32); end
        flush = 1'b1; in_tag = 8'h53;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (vld32 !== 1'b0 || rdy32 !== 1'b1 || vld64 !== 1'b0) begin n_fail++; $display("FAIL flush_next: got v=%b r=%b v64=%b want v=0 r=1", vld32, rdy32, vld64); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got %b/%b want 0/0", i, vld32, vld64); end
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 8'h54;
        @(negedge clk);
        flush = 1'b1; in_tag = 8'h55;
        n_tests++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL flush_rdy_hi: got %b want 1", rdy32); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", vld32); end
        @(negedge clk);
        n_tests++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin n_fail++; $display("FAIL flush_drop2: got %b/%b want 0/0", vld32, vld64); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h800002B7; in_tag = 8'h61;
        @(negedge clk);
        in_tag = 8'h62;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (rdy32 !== 1'b0 || vld32 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got r=%b v=%b want r=0 v=1", rdy32, vld32); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (vld32 !== 1'b0 || rdy32 !== 1'b1 || vld64 !== 1'b0 || rdy64 !== 1'b1) begin n_fail++; $display("FAIL rstmid_hs: got v=%b r=%b v64=%b r64=%b want v=0 r=1", vld32, rdy32, vld64, rdy64); end
        n_tests++; if ({imm32, typ32, ill32, tag32} !== 44'h0 || {imm64, typ64, ill64, tag64} !== 76'h0) begin n_fail++; $display("FAIL rstmid_data: got %h/%h want 0", {imm32, tag32}, {imm64, tag64}); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (vld32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %b want 0", vld32); end
    endtask

    task automatic test_random();
        bit          acc, pop, ill_a, ill_b;
        logic [2:0]  ta, tb;
        longint      va, vb;
        logic [63:0] ea, eb;
        logic [39:0] hd;
        q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            n_tests++; if (vld32 !== (q.size() > 0) || vld64 !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b/%b want %b", cyc, vld32, vld64, q.size() > 0); end
            n_tests++; if (rdy32 !== (q.size() < 2) || rdy64 !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b/%b want %b", cyc, rdy32, rdy64, q.size() < 2); end
            if (q.size() > 0) begin
                hd = q[0];
                ref_dec(hd[31:0], 1'b0, ill_a, ta, va);
                ref_dec(hd[31:0], 1'b1, ill_b, tb, vb);
                ea = va; eb = vb;
                n_tests++; if (typ32 !== ta || ill32 !== ill_a || tag32 !== hd[39:32]) begin n_fail++; $display("FAIL rnd_fields32@%0d inst=%h: got t=%0d ill=%b tag=%h want t=%0d ill=%b tag=%h", cyc, hd[31:0], typ32, ill32, tag32, ta, ill_a, hd[39:32]); end
                n_tests++; if (imm32 !== ea[31:0]) begin n_fail++; $display("FAIL rnd_imm32@%0d inst=%h: got %h want %h", cyc, hd[31:0], imm32, ea[31:0]); end
                n_tests++; if (typ64 !== tb || ill64 !== ill_b || tag64 !== hd[39:32]) begin n_fail++; $display("FAIL rnd_fields64@%0d inst=%h: got t=%0d ill=%b tag=%h want t=%0d ill=%b tag=%h", cyc, hd[31:0], typ64, ill64, tag64, tb, ill_b, hd[39:32]); end
                n_tests++; if (imm64 !== eb) begin n_fail++; $display("FAIL rnd_imm64@%0d inst=%h: got %h want %h", cyc, hd[31:0], imm64, eb); end
            end
            in_valid  = ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 65);
            flush     = ($urandom_range(99) < 3);
            in_inst   = gen_inst();
            in_tag    = 8'($urandom);
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back({in_tag, in_inst});
            end
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        op_tab = '{5'b00100, 5'b00000, 5'b11001, 5'b00110, 5'b01000, 5'b11000,
                   5'b00101, 5'b01101, 5'b11011, 5'b11100, 5'b01110, 5'b10100};
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
